// File: rtl/br_pkg.sv
// Shared definitions for the buffer-register family: default widths and a
// constant-evaluable ceil(log2) used to size pointers and occupancy counters.
package br_pkg;

    localparam int BR_DATA_WIDTH = 32;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/br_ptr_ctr.sv
// Circular index counter for a DEPTH-entry buffer. Wraps by explicit compare so
// DEPTH need not be a power of two; clr returns the index to entry 0.
module br_ptr_ctr
    import br_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    // Index register: clear wins over increment, last entry wraps to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/br_elastic_buf.sv
// DEPTH-entry FIFO elastic buffer with valid/ready on both sides, synchronous
// flush and an occupancy count. All outputs decode from registered state only.
module br_elastic_buf
    import br_pkg::*;
#(
    parameter int DATA_WIDTH = BR_DATA_WIDTH,
    parameter int DEPTH = 4,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CNT_W-1:0]      r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;

    // Handshake decode: flush suppresses both sides so a dropped word never lands in storage.
    always_comb begin
        w_in_ready  = (r_count != FULL_CNT);
        w_out_valid = (r_count != '0);
        w_push      = in_valid & w_in_ready & ~flush;
        w_pop       = w_out_valid & out_ready & ~flush;
    end

    br_ptr_ctr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_push),
        .ptr (w_wr_ptr)
    );

    br_ptr_ctr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_pop),
        .ptr (w_rd_ptr)
    );

    // Storage: cleared on reset so out_data is never X; flush leaves contents alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    // Occupancy: moves only when exactly one of push/pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_mem[w_rd_ptr];
    assign count     = r_count;

endmodule

// File: tb/tb_br_elastic_buf.sv
// Self-checking bench: DEPTH=4 and DEPTH=3 instances checked every cycle against
// queue-based FIFO models, plus directed reset, fill/drain, flush and streaming cases.
module tb_br_elastic_buf;

    localparam int A_DEPTH = 4;
    localparam int B_DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [2:0]  a_count;

    logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_count;

    br_elastic_buf #(.DATA_WIDTH(32), .DEPTH(A_DEPTH)) u_dut_a (
        .clk (clk), .rst (rst), .flush (a_flush),
        .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
        .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data),
        .count (a_count)
    );

    br_elastic_buf #(.DATA_WIDTH(32), .DEPTH(B_DEPTH)) u_dut_b (
        .clk (clk), .rst (rst), .flush (b_flush),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
        .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
        .count (b_count)
    );

    // Reference models: plain FIFOs of accepted words.
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    bit          a_pushed, b_pushed;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the buffer rules to the models for the edge that just happened.
    task automatic model_step();
        bit push, pop;
        a_pushed = 0;
        b_pushed = 0;
        if (rst) begin
            q_a.delete();
            q_b.delete();
            return;
        end
        push = a_in_valid && (q_a.size() < A_DEPTH);
        pop  = a_out_ready && (q_a.size() > 0);
        if (a_flush) q_a.delete();
        else begin
            if (pop) void'(q_a.pop_front());
            if (push) q_a.push_back(a_in_data);
            a_pushed = push;
        end
        push = b_in_valid && (q_b.size() < B_DEPTH);
        pop  = b_out_ready && (q_b.size() > 0);
        if (b_flush) q_b.delete();
        else begin
            if (pop) void'(q_b.pop_front());
            if (push) q_b.push_back(b_in_data);
            b_pushed = push;
        end
    endtask

    task automatic check_outputs();
        chk("a_count", 32'(a_count), 32'(q_a.size()));
        chk("a_in_ready", 32'(a_in_ready), 32'(q_a.size() != A_DEPTH));
        chk("a_out_valid", 32'(a_out_valid), 32'(q_a.size() != 0));
        if (q_a.size() != 0) chk("a_out_data", a_out_data, q_a[0]);
        chk("b_count", 32'(b_count), 32'(q_b.size()));
        chk("b_in_ready", 32'(b_in_ready), 32'(q_b.size() != B_DEPTH));
        chk("b_out_valid", 32'(b_out_valid), 32'(q_b.size() != 0));
        if (q_b.size() != 0) chk("b_out_data", b_out_data, q_b[0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_a();
        a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    endtask

    task automatic push_a(input logic [31:0] d);
        a_in_valid = 1; a_in_data = d; a_out_ready = 0;
        cycle();
        a_in_valid = 0;
    endtask

    task automatic reset_pulse();
        rst = 1;
        #1;
        q_a.delete();
        q_b.delete();
        cycle();
        rst = 0;
    endtask

    initial begin
        int pushed;
        int guard;

        // Power-on reset
        #2 rst = 1;
        #1;
        chk("por_count", 32'(a_count), 0);
        chk("por_in_ready", 32'(a_in_ready), 1);
        chk("por_out_valid", 32'(a_out_valid), 0);
        chk("por_out_data", a_out_data, 0);
        cycle();
        cycle();
        rst = 0;

        // 1: async reset with count=3, then first push visible next cycle
        push_a(32'h1);
        push_a(32'h2);
        push_a(32'h3);
        chk("pre_rst_count", 32'(a_count), 3);
        rst = 1;
        #1;
        q_a.delete();
        q_b.delete();
        chk("rst_count", 32'(a_count), 0);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_in_ready", 32'(a_in_ready), 1);
        chk("rst_out_data", a_out_data, 0);
        cycle();
        rst = 0;
        push_a(32'hA5A5_0001);
        chk("rst_first_data", a_out_data, 32'hA5A5_0001);
        chk("rst_first_valid", 32'(a_out_valid), 1);
        reset_pulse();

        // 2: fill, hold off 5th word, drain in order
        push_a(32'h11);
        push_a(32'h22);
        push_a(32'h33);
        push_a(32'h44);
        chk("fill_count", 32'(a_count), 4);
        chk("fill_in_ready", 32'(a_in_ready), 0);
        a_in_valid = 1; a_in_data = 32'h55;
        cycle();
        chk("hold_count", 32'(a_count), 4);
        a_out_ready = 1;
        guard = 0;
        while (q_a.size() != 0 && guard < 20) begin
            cycle();
            if (a_pushed) a_in_valid = 0;
            guard++;
        end
        chk("drain_done", 32'(a_count), 0);
        idle_a();

        // 3: full + simultaneous pop -> pop only, push next cycle
        for (int i = 0; i < 4; i++) push_a(32'h100 + 32'(i));
        a_in_valid = 1; a_in_data = 32'h1FF; a_out_ready = 1;
        cycle();
        chk("fullpop_count", 32'(a_count), 3);
        a_out_ready = 0;
        cycle();
        chk("fullpop_refill", 32'(a_count), 4);
        idle_a();
        reset_pulse();

        // 4: streaming, count stays 1 and data follows the cycle index
        for (int i = 0; i < 20; i++) begin
            a_in_valid = 1; a_in_data = 32'(i); a_out_ready = 1;
            cycle();
            chk("stream_count", 32'(a_count), 1);
            chk("stream_seq", a_out_data, 32'(i));
        end
        idle_a();
        cycle();
        cycle();
        reset_pulse();

        // 5: flush with push+pop; wr_ptr sits at 0 so a leaked write would show
        for (int i = 0; i < 4; i++) push_a(32'h200 + 32'(i));
        a_out_ready = 1;
        cycle();
        cycle();
        a_out_ready = 0;
        chk("preflush_count", 32'(a_count), 2);
        a_in_valid = 1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 1; a_flush = 1;
        cycle();
        idle_a();
        chk("flush_count", 32'(a_count), 0);
        chk("flush_out_valid", 32'(a_out_valid), 0);
        chk("flush_dropped", 32'(a_out_data == 32'hDEAD_BEEF), 0);
        push_a(32'h77);
        chk("postflush_data", a_out_data, 32'h77);
        reset_pulse();

        // 6: DEPTH=3, seven words with random consumer
        pushed = 0;
        guard = 0;
        while (pushed < 7 && guard < 200) begin
            b_in_valid = 1;
            b_in_data = 32'h300 + 32'(pushed);
            b_out_ready = 1'($urandom_range(0, 1));
            cycle();
            chk("b_cnt_bound", 32'(b_count <= 2'd3), 1);
            if (b_pushed) pushed++;
            guard++;
        end
        chk("b_pushed", 32'(pushed), 7);
        b_in_valid = 0; b_out_ready = 1;
        guard = 0;
        while (q_b.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("b_drained", 32'(b_count), 0);
        b_out_ready = 0;

        // Random traffic on both instances, occasional flush on the DEPTH=4 one
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = $urandom;
            a_out_ready = 1'($urandom_range(0, 1));
            a_flush     = ($urandom_range(0, 15) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = $urandom;
            b_out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_a();
        b_in_valid = 0; b_out_ready = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
